// File: rtl/sram_like_bridge.sv
// rtl/sram_like_bridge.sv - single-outstanding CPU to sram-like memory bridge
module sram_like_bridge #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en,
    input  logic [DATA_W/8-1:0] cpu_wen,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    input  logic                ext_stall,
    input  logic                flush,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [2:0]          mem_size,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int NB = DATA_W / 8;
    localparam logic [2:0] FULL_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;
    localparam logic [NB-1:0] LANE1 = NB'(1);
    localparam logic [NB-1:0] LANE2 = NB'(3);
    localparam logic [NB-1:0] LANE4 = NB'(15);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t     state_q, state_d;
    logic       cancel_q, cancel_d;
    logic       accept;
    logic       capture;
    logic [2:0] size_dec;

    // Only naturally aligned 1/2/4-byte patterns shrink the size; anything else is a full-width write.
    always_comb begin
        size_dec = FULL_SIZE;
        for (int i = 0; i < NB; i++)
            if (cpu_wen == (LANE1 << i)) size_dec = 3'd0;
        for (int i = 0; i < NB; i += 2)
            if (cpu_wen == (LANE2 << i)) size_dec = 3'd1;
        for (int i = 0; i < NB; i += 4)
            if (cpu_wen == (LANE4 << i)) size_dec = 3'd2;
    end

    assign accept    = (state_q == IDLE) && cpu_en && !flush;
    assign mem_req   = (state_q == REQ);
    assign cpu_stall = rst && ((state_q == REQ) || (state_q == WAIT) || accept);

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        capture  = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                if (flush) cancel_d = 1'b1;
                if (mem_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (mem_data_ok) begin
                    cancel_d = 1'b0;
                    if (cancel_q) begin
                        state_d = IDLE;
                    end else begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end else if (flush) begin
                    cancel_d = 1'b1;
                end
            end
            HOLD: if (!ext_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
        end
    end

    // Request fields are only loaded on acceptance, so they stay frozen while mem_req is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wr    <= 1'b0;
            mem_size  <= 3'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            mem_wr    <= |cpu_wen;
            mem_size  <= size_dec;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata <= '0;
        end else if (capture) begin
            cpu_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_sram_like_bridge.sv
// tb/tb_sram_like_bridge.sv - directed and randomized checks of sram_like_bridge
module tb_sram_like_bridge;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cpu_en, cpu_stall, ext_stall, flush;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        rst64, en64, stall64, req64, wr64;
    logic [7:0]  wen64;
    logic [31:0] addr64, maddr64;
    logic [63:0] wdata64, rdata64, mwdata64, mrdata64;
    logic [2:0]  size64;

    sram_like_bridge #(.DATA_W(32), .ADDR_W(32)) u_dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_stall(ext_stall), .flush(flush), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    sram_like_bridge #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst64), .cpu_en(en64), .cpu_wen(wen64), .cpu_addr(addr64),
        .cpu_wdata(wdata64), .cpu_rdata(rdata64), .cpu_stall(stall64),
        .ext_stall(1'b0), .flush(1'b0), .mem_req(req64), .mem_wr(wr64),
        .mem_size(size64), .mem_addr(maddr64), .mem_wdata(mwdata64),
        .mem_addr_ok(1'b0), .mem_data_ok(1'b0), .mem_rdata(mrdata64)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: where the transaction is, plus the request and hold values it implies.
    bit          m_req, m_wait, m_hold, m_cancel;
    logic [31:0] m_rd, m_addr, m_wdata;
    logic        m_wr;
    logic [2:0]  m_size;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_size(input logic [7:0] w, input int nb);
        int n, lo, wv;
        logic [2:0] full;
        full = (nb == 8) ? 3'd3 : 3'd2;
        n = 0; lo = -1; wv = int'(w);
        for (int i = 0; i < nb; i++)
            if (w[i]) begin
                n++;
                if (lo < 0) lo = i;
            end
        if (n == 0) return full;
        if (n == 1) return 3'd0;
        if (((wv >> lo) == ((1 << n) - 1)) && (lo % n == 0)) begin
            if (n == 2) return 3'd1;
            if (n == 4) return 3'd2;
            if (n == 8) return 3'd3;
        end
        return full;
    endfunction

    task automatic model_reset();
        m_req = 0; m_wait = 0; m_hold = 0; m_cancel = 0;
        m_rd = '0; m_addr = '0; m_wdata = '0; m_wr = 0; m_size = '0;
    endtask

    task automatic model_step();
        if (!(m_req || m_wait || m_hold)) begin
            if (cpu_en && !flush) begin
                m_wr = |cpu_wen; m_size = exp_size({4'b0, cpu_wen}, 4);
                m_addr = cpu_addr; m_wdata = cpu_wdata; m_req = 1;
            end
        end else if (m_req) begin
            if (flush) m_cancel = 1;
            if (mem_addr_ok) begin m_req = 0; m_wait = 1; end
        end else if (m_wait) begin
            if (mem_data_ok) begin
                m_wait = 0;
                if (m_cancel) m_cancel = 0;
                else begin m_rd = mem_rdata; m_hold = 1; end
            end else if (flush) m_cancel = 1;
        end else if (!ext_stall) begin
            m_hold = 0;
        end
    endtask

    task automatic check_all();
        logic idle;
        idle = !(m_req || m_wait || m_hold);
        chk("mem_req", mem_req, m_req);
        chk("cpu_stall", cpu_stall, m_req || m_wait || (idle && cpu_en && !flush));
        chk("cpu_rdata", cpu_rdata, m_rd);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_wr", mem_wr, m_wr);
        chk("mem_size", mem_size, m_size);
    endtask

    task automatic tick();
        #2;
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic [7:0] pats [9];
        pats = '{8'hFF, 8'h0F, 8'hF0, 8'h30, 8'h18, 8'h01, 8'h80, 8'h00, 8'h07};
        rst = 1; rst64 = 1;
        cpu_en = 1; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0; ext_stall = 0; flush = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        en64 = 0; wen64 = 0; addr64 = 32'h40; wdata64 = 64'h0123_4567_89AB_CDEF; mrdata64 = 0;
        #1 rst = 0; rst64 = 0;
        #2;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_cpu_stall", cpu_stall, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_mem_size", mem_size, 3'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1; cpu_en = 0;
        model_reset();

        // Read with addr_ok in cycle 2, data_ok in cycle 4
        cpu_en = 1; cpu_wen = 0; cpu_addr = 32'h1000; tick();
        chk("rd_size", mem_size, 3'd2);
        tick();
        mem_addr_ok = 1; tick();
        mem_addr_ok = 0; tick();
        mem_data_ok = 1; mem_rdata = 32'hDEADBEEF; tick();
        mem_data_ok = 0; cpu_en = 0; #1;
        chk("rd_data", cpu_rdata, 32'hDEADBEEF);
        chk("rd_stall_off", cpu_stall, 1'b0);
        tick();

        // Single-byte write
        cpu_en = 1; cpu_wen = 4'b0100; cpu_wdata = 32'h00AB0000; cpu_addr = 32'h2002; tick();
        chk("bw_wr", mem_wr, 1'b1);
        chk("bw_size", mem_size, 3'd0);
        mem_addr_ok = 1; tick();
        mem_addr_ok = 0; mem_data_ok = 1; tick();
        mem_data_ok = 0; cpu_en = 0; #1;
        chk("bw_stall_off", cpu_stall, 1'b0);
        tick();

        // Flush while waiting for data
        cpu_en = 1; cpu_wen = 0; cpu_addr = 32'h3000; tick();
        mem_addr_ok = 1; tick();
        mem_addr_ok = 0; flush = 1; cpu_en = 0; tick();
        flush = 0; #1;
        chk("fl_stall_held", cpu_stall, 1'b1);
        tick();
        mem_data_ok = 1; mem_rdata = 32'h12345678; tick();
        mem_data_ok = 0;
        chk("fl_rdata_kept", cpu_rdata, 32'hDEADBEEF);
        cpu_en = 1; #1;
        chk("fl_back_idle", cpu_stall, 1'b1);

        // Hold under external stall with spurious data_ok
        cpu_wen = 0; cpu_addr = 32'h4000; tick();
        mem_addr_ok = 1; tick();
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hCAFEF00D; tick();
        ext_stall = 1; mem_rdata = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_rdata", cpu_rdata, 32'hCAFEF00D);
            chk("hold_stall", cpu_stall, 1'b0);
            chk("hold_no_req", mem_req, 1'b0);
            tick();
        end
        ext_stall = 0; mem_data_ok = 0; cpu_en = 0; tick();

        // Reset asserted while requesting
        cpu_en = 1; cpu_wen = 0; cpu_addr = 32'h5000; tick();
        #2 rst = 0;
        #1;
        chk("rst_req_drop", mem_req, 1'b0);
        chk("rst_stall_drop", cpu_stall, 1'b0);
        chk("rst_rdata_clr", cpu_rdata, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1; cpu_en = 0; mem_data_ok = 1; mem_rdata = 32'h99999999; tick();
        chk("stale_data_ok", cpu_rdata, 32'h0);
        mem_data_ok = 0; tick();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cpu_en      = ($urandom_range(0, 9) < 6);
            cpu_wen     = 4'($urandom_range(0, 15));
            cpu_addr    = $urandom;
            cpu_wdata   = $urandom;
            flush       = ($urandom_range(0, 9) == 0);
            ext_stall   = ($urandom_range(0, 9) < 4);
            mem_addr_ok = ($urandom_range(0, 9) < 4);
            mem_data_ok = ($urandom_range(0, 9) < 4);
            mem_rdata   = $urandom;
            tick();
        end

        // 64-bit instance size decode, one fresh request per pattern
        en64 = 1;
        foreach (pats[k]) begin
            wen64 = pats[k];
            rst64 = 0; #1;
            chk("w64_rst_req", req64, 1'b0);
            rst64 = 1;
            @(posedge clk); #1;
            chk("w64_req", req64, 1'b1);
            chk("w64_size", size64, exp_size(pats[k], 8));
            chk("w64_wr", wr64, |pats[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
